// File: rtl/v850_mem_pkg.sv
// Shared definitions for the DDR3 port arbiter: FSM state encoding,
// DDR3 IP command codes and default bus widths.
package v850_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RWAIT,
        DONE
    } arb_state_t;

    localparam logic [2:0] DDR_CMD_READ  = 3'b001;
    localparam logic [2:0] DDR_CMD_WRITE = 3'b000;

    localparam int DFLT_ADDR_W = 29;
    localparam int DFLT_DATA_W = 256;
    localparam int DFLT_MASK_W = 32;

endpackage

// File: rtl/ddr3_arb_pick.sv
// Combinational winner selection between the fetch port (0) and the
// memory-access port (1).
// Build option ARB_ROUND_ROBIN_EN: when defined, contention is resolved in
// favour of the port not granted most recently; otherwise port 1 always wins.
module ddr3_arb_pick (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    input  logic req0,
    input  logic req1,
    output logic grant_valid,
    output logic grant_port
);

    // Pick a winner; a lone requester always wins.
    always_comb begin
        grant_valid = req0 | req1;
`ifdef ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = req1;
        end
`else
        grant_port = req1;
`endif
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Two-port arbiter in front of the DDR3 controller IP user interface.
// Port 0 = instruction fetch, port 1 = memory-access stage. One transaction
// at a time: arbitrate, issue command, move one data beat, acknowledge.
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default: fixed priority, port 1 over port 0).
module ddr3_port_arbiter
    import v850_mem_pkg::*;
#(
    parameter int ADDR_W = DFLT_ADDR_W,
    parameter int DATA_W = DFLT_DATA_W,
    parameter int MASK_W = DFLT_MASK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              init_calib_complete,
    input  logic              cmd_ready,
    output logic [2:0]        cmd,
    output logic              cmd_en,
    output logic [ADDR_W-1:0] addr,
    input  logic              wr_data_rdy,
    output logic              wr_data_en,
    output logic              wr_data_end,
    output logic [DATA_W-1:0] wr_data,
    output logic [MASK_W-1:0] wr_data_mask,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              busy
);

    arb_state_t state;
    logic       port_q;     // granted port of the transaction in flight
    logic       we_q;       // direction of the transaction in flight
    logic       grant_valid;
    logic       grant_port;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_grant;
`endif

    // Every byte of a beat is always written.
    assign wr_data_mask = '0;

    ddr3_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant),
`endif
        .req0        (req0),
        .req1        (req1),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Transaction sequencer; all user-side and IP-side outputs registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            cmd         <= DDR_CMD_WRITE;
            cmd_en      <= 1'b0;
            addr        <= '0;
            wr_data     <= '0;
            wr_data_en  <= 1'b0;
            wr_data_end <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            busy        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant  <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    // Requests stay pending until the IP finishes calibration.
                    if (init_calib_complete && grant_valid) begin
                        port_q  <= grant_port;
                        we_q    <= grant_port ? we1 : we0;
                        addr    <= grant_port ? addr1 : addr0;
                        wr_data <= grant_port ? wdata1 : wdata0;
                        cmd     <= (grant_port ? we1 : we0) ? DDR_CMD_WRITE : DDR_CMD_READ;
                        cmd_en  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CMD;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= grant_port;
`endif
                    end
                end
                CMD: begin
                    if (cmd_ready) begin
                        cmd_en <= 1'b0;
                        if (we_q) begin
                            wr_data_en  <= 1'b1;
                            wr_data_end <= 1'b1;
                            state       <= WDATA;
                        end else begin
                            state <= RWAIT;
                        end
                    end
                end
                WDATA: begin
                    if (wr_data_rdy) begin
                        wr_data_en  <= 1'b0;
                        wr_data_end <= 1'b0;
                        ack0        <= ~port_q;
                        ack1        <= port_q;
                        state       <= DONE;
                    end
                end
                RWAIT: begin
                    if (rd_data_valid) begin
                        if (port_q) begin
                            rdata1 <= rd_data;
                        end else begin
                            rdata0 <= rd_data;
                        end
                        ack0  <= ~port_q;
                        ack1  <= port_q;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    cmd_en      <= 1'b0;
                    wr_data_en  <= 1'b0;
                    wr_data_end <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed testbench for ddr3_port_arbiter with hand-computed expectations.
module tb_ddr3_port_arbiter;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 256;
    localparam int MASK_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              init_calib_complete, cmd_ready;
    logic [2:0]        cmd;
    logic              cmd_en;
    logic [ADDR_W-1:0] addr;
    logic              wr_data_rdy, wr_data_en, wr_data_end;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] wr_data_mask;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req0                (req0),
        .req1                (req1),
        .we0                 (we0),
        .we1                 (we1),
        .addr0               (addr0),
        .addr1               (addr1),
        .wdata0              (wdata0),
        .wdata1              (wdata1),
        .ack0                (ack0),
        .ack1                (ack1),
        .rdata0              (rdata0),
        .rdata1              (rdata1),
        .init_calib_complete (init_calib_complete),
        .cmd_ready           (cmd_ready),
        .cmd                 (cmd),
        .cmd_en              (cmd_en),
        .addr                (addr),
        .wr_data_rdy         (wr_data_rdy),
        .wr_data_en          (wr_data_en),
        .wr_data_end         (wr_data_end),
        .wr_data             (wr_data),
        .wr_data_mask        (wr_data_mask),
        .rd_data             (rd_data),
        .rd_data_valid       (rd_data_valid),
        .busy                (busy)
    );

    task automatic check_vec(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] pat_a5;
    logic [DATA_W-1:0] pat_77;
    logic [1:0]        exp_ord [4];
    logic              got;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_77 = {32{8'h77}};
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord[0] = 2'b10; exp_ord[1] = 2'b01; exp_ord[2] = 2'b10; exp_ord[3] = 2'b01;
`else
        exp_ord[0] = 2'b10; exp_ord[1] = 2'b10; exp_ord[2] = 2'b10; exp_ord[3] = 2'b10;
`endif
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        init_calib_complete = 0; cmd_ready = 0; wr_data_rdy = 0;
        rd_data = '0; rd_data_valid = 0;

        // ---- reset state
        tick; tick;
        check_vec("rst_cmd_en", cmd_en, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_ack", {ack1, ack0}, 0);
        check_vec("rst_cmd", cmd, 0);
        check_vec("rst_addr", addr, 0);
        check_vec("rst_wr_en_end", {wr_data_en, wr_data_end}, 0);
        check_vec("rst_rdata0", rdata0, 0);
        check_vec("rst_mask", wr_data_mask, 0);
        rst_n = 1'b1;
        tick;

        // ---- calibration gate: port 0 read held off while calibrating
        req0 = 1; we0 = 0; addr0 = 29'h55;
        for (int i = 0; i < 10; i++) begin
            tick;
            check_vec("calib_hold_cmd_en", cmd_en, 0);
        end
        init_calib_complete = 1;
        tick;
        check_vec("calib_cmd_en", cmd_en, 1);
        check_vec("calib_cmd", cmd, 3'b001);
        check_vec("calib_addr", addr, 29'h55);
        cmd_ready = 1;
        tick;
        check_vec("calib_rwait_cmd_en", cmd_en, 0);
        rd_data_valid = 1; rd_data = pat_77;
        tick;
        check_vec("calib_ack0", {ack1, ack0}, 2'b01);
        check_vec("calib_rdata0", rdata0, pat_77);
        req0 = 0; rd_data_valid = 0;
        tick;
        check_vec("calib_ack_pulse", {ack1, ack0}, 0);
        tick;
        check_vec("calib_idle_busy", busy, 0);

        // ---- read with stalls on port 1
        cmd_ready = 0;
        req1 = 1; we1 = 0; addr1 = 29'h2000;
        tick;
        check_vec("rd_cmd_en_c1", cmd_en, 1);
        tick;
        check_vec("rd_cmd_en_c2", cmd_en, 1);
        tick;
        check_vec("rd_cmd_en_c3", cmd_en, 1);
        check_vec("rd_addr", addr, 29'h2000);
        cmd_ready = 1;
        tick;
        check_vec("rd_accepted", {busy, cmd_en}, 2'b10);
        for (int i = 0; i < 7; i++) begin
            tick;
            check_vec("rd_wait_noack", {ack1, ack0}, 0);
        end
        rd_data_valid = 1; rd_data = 256'h1234;
        tick;
        check_vec("rd_ack1", {ack1, ack0}, 2'b10);
        check_vec("rd_rdata1", rdata1, 256'h1234);
        check_vec("rd_rdata0_held", rdata0, pat_77);
        req1 = 0; rd_data_valid = 0;
        tick;
        tick;

        // ---- single write on port 0
        wr_data_rdy = 1;
        req0 = 1; we0 = 1; addr0 = 29'h100; wdata0 = pat_a5;
        tick;
        check_vec("wr_c1_cmd_en", {cmd_en, wr_data_en}, 2'b10);
        check_vec("wr_c1_cmd", cmd, 3'b000);
        check_vec("wr_c1_addr", addr, 29'h100);
        check_vec("wr_c1_ack", {ack1, ack0}, 0);
        tick;
        check_vec("wr_c2_en_end", {cmd_en, wr_data_en, wr_data_end}, 3'b011);
        check_vec("wr_c2_data", wr_data, pat_a5);
        check_vec("wr_c2_addr_stable", addr, 29'h100);
        check_vec("wr_c2_ack", {ack1, ack0}, 0);
        tick;
        check_vec("wr_c3_ack0", {ack1, ack0}, 2'b01);
        check_vec("wr_c3_en", wr_data_en, 0);
        req0 = 0;
        tick;
        check_vec("wr_c4_ack", {ack1, ack0}, 0);
        tick;

        // ---- stray read data while idle
        rd_data_valid = 1; rd_data = 256'hDEAD;
        tick;
        tick;
        check_vec("stray_ack", {ack1, ack0}, 0);
        check_vec("stray_rdata0", rdata0, pat_77);
        check_vec("stray_rdata1", rdata1, 256'h1234);
        check_vec("stray_busy", busy, 0);
        rd_data_valid = 0;

        // ---- contention: both ports reading, four back-to-back grants
        req0 = 1; we0 = 0; addr0 = 29'h0A;
        req1 = 1; we1 = 0; addr1 = 29'h0B;
        for (int t = 0; t < 4; t++) begin
            got = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                rd_data_valid = busy && !cmd_en && !ack0 && !ack1;
                rd_data = DATA_W'(t + 1);
                tick;
                if (ack0 || ack1) got = 1;
            end
            check_vec("contention_order", {ack1, ack0}, exp_ord[t]);
            check_vec("contention_rdata", ack1 ? rdata1 : rdata0, DATA_W'(t + 1));
        end
        req0 = 0; req1 = 0; rd_data_valid = 0;
        tick;
        tick;

        // ---- reset in the middle of a write
        wr_data_rdy = 0;
        req0 = 1; we0 = 1; addr0 = 29'h300; wdata0 = pat_a5;
        tick;
        tick;
        check_vec("mid_wdata_en", wr_data_en, 1);
        rst_n = 0;
        #1;
        check_vec("mid_rst_ctrl", {cmd_en, wr_data_en, wr_data_end, busy, ack1, ack0}, 0);
        check_vec("mid_rst_addr", addr, 0);
        check_vec("mid_rst_wr_data", wr_data, 0);
        check_vec("mid_rst_rdata", rdata0 | rdata1, 0);
        wr_data_rdy = 1;
        tick;
        check_vec("mid_rst_noack", {ack1, ack0}, 0);
        rst_n = 1;
        tick;
        check_vec("post_rst_cmd_en", cmd_en, 1);
        check_vec("post_rst_addr", addr, 29'h300);
        tick;
        check_vec("post_rst_wr_en", wr_data_en, 1);
        tick;
        check_vec("post_rst_ack0", {ack1, ack0}, 2'b01);
        req0 = 0;
        tick;
        check_vec("post_rst_ack_clear", {ack1, ack0}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
